// File: rtl/fa_tag_lookup_pkg.sv
// Shared types and width helpers for the fully-associative tag lookup.
// Holds the sequencer state encoding and the location-index width rule.
package cache_lookup_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPARE = 2'd1,
      ST_WB      = 2'd2,
      ST_FILL    = 2'd3
   } state_t;

   localparam int unsigned N_LOCATIONS_DEF = 8;
   localparam int unsigned BW_TAG_DEF      = 24;

   // A single-bit index is still needed when only two locations exist.
   function automatic int unsigned loc_width(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned BW_LOC_DEF = loc_width(N_LOCATIONS_DEF);

endpackage

// File: rtl/fa_tag_lookup_if.sv
// Request, PLRU and memory-side handshake bundle for fa_tag_lookup.
// slave is the lookup block's view; master is the surrounding environment.
interface fa_tag_lookup_if
   import cache_lookup_pkg::*;
#(
   parameter int unsigned N_LOCATIONS = N_LOCATIONS_DEF,
   parameter int unsigned BW_TAG      = BW_TAG_DEF
) ();

   localparam int unsigned BW_LOC = loc_width(N_LOCATIONS);

   logic              req_i;
   logic [BW_TAG-1:0] tag_i;
   logic              rw_i;
   logic              ready_o;
   logic              done_o;
   logic              hit_o;
   logic [BW_LOC-1:0] loc_o;

   logic [BW_LOC-1:0] plru_victim_i;
   logic              plru_en_o;
   logic [BW_LOC-1:0] plru_addr_o;

   logic              wb_req_o;
   logic [BW_TAG-1:0] wb_tag_o;
   logic [BW_LOC-1:0] wb_loc_o;
   logic              wb_ack_i;

   logic              fill_req_o;
   logic [BW_TAG-1:0] fill_tag_o;
   logic [BW_LOC-1:0] fill_loc_o;
   logic              fill_ack_i;

   modport slave (
      input  req_i, tag_i, rw_i, plru_victim_i, wb_ack_i, fill_ack_i,
      output ready_o, done_o, hit_o, loc_o, plru_en_o, plru_addr_o,
             wb_req_o, wb_tag_o, wb_loc_o, fill_req_o, fill_tag_o, fill_loc_o
   );

   modport master (
      output req_i, tag_i, rw_i, plru_victim_i, wb_ack_i, fill_ack_i,
      input  ready_o, done_o, hit_o, loc_o, plru_en_o, plru_addr_o,
             wb_req_o, wb_tag_o, wb_loc_o, fill_req_o, fill_tag_o, fill_loc_o
   );

endinterface

// File: rtl/fa_tag_lookup_enc.sv
// Parallel tag compare with lowest-index priority encode and any-match flag.
// With cmp_en_i low it simply encodes mask_i (used for first-invalid search).
module tag_match_encoder #(
   parameter int unsigned N      = 8,
   parameter int unsigned BW_TAG = 24,
   parameter int unsigned BW_IDX = 3
) (
   input  logic [N-1:0][BW_TAG-1:0] tags_i,
   input  logic [BW_TAG-1:0]        key_i,
   input  logic [N-1:0]             mask_i,
   input  logic                     cmp_en_i,
   output logic                     any_o,
   output logic [BW_IDX-1:0]        idx_o
);

   logic [N-1:0] match;

   always_comb begin
      match = '0;
      for (int unsigned i = 0; i < N; i++) begin
         match[i] = mask_i[i] & (~cmp_en_i | (tags_i[i] == key_i));
      end
   end

   // Scan downward so the lowest matching index is the last one written.
   always_comb begin
      idx_o = '0;
      for (int unsigned i = N; i > 0; i--) begin
         if (match[i-1]) idx_o = BW_IDX'(i - 1);
      end
   end

   assign any_o = |match;

endmodule

// File: rtl/fa_tag_lookup.sv
// Fully-associative tag lookup and miss sequencer: tag/valid/dirty store,
// hit/victim resolution, write-back and fill handshakes, PLRU update pulse.
module fa_tag_lookup
   import cache_lookup_pkg::*;
#(
   parameter int unsigned N_LOCATIONS = N_LOCATIONS_DEF,
   parameter int unsigned BW_TAG      = BW_TAG_DEF
) (
   input  logic           clock_i,
   input  logic           resetn_i,
   fa_tag_lookup_if.slave bus
);

   localparam int unsigned BW_LOC = loc_width(N_LOCATIONS);

   state_t state_q, state_d;

   logic [N_LOCATIONS-1:0][BW_TAG-1:0] tag_q;
   logic [N_LOCATIONS-1:0]             valid_q;
   logic [N_LOCATIONS-1:0]             dirty_q;

   logic [BW_TAG-1:0] req_tag_q;
   logic              req_rw_q;
   logic [BW_LOC-1:0] victim_q, victim_d;

   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              hit_q, hit_d;
   logic [BW_LOC-1:0] loc_q, loc_d;
   logic              wb_req_q, wb_req_d;
   logic [BW_TAG-1:0] wb_tag_q, wb_tag_d;
   logic [BW_LOC-1:0] wb_loc_q, wb_loc_d;
   logic              fill_req_q, fill_req_d;
   logic [BW_TAG-1:0] fill_tag_q, fill_tag_d;
   logic [BW_LOC-1:0] fill_loc_q, fill_loc_d;

   logic              accept;
   logic              mark_dirty;
   logic              install;
   logic [BW_LOC-1:0] miss_victim;

   logic              hit_any, inv_any;
   logic [BW_LOC-1:0] hit_idx, inv_idx;

   tag_match_encoder #(
      .N      (N_LOCATIONS),
      .BW_TAG (BW_TAG),
      .BW_IDX (BW_LOC)
   ) u_hit_enc (
      .tags_i   (tag_q),
      .key_i    (req_tag_q),
      .mask_i   (valid_q),
      .cmp_en_i (1'b1),
      .any_o    (hit_any),
      .idx_o    (hit_idx)
   );

   tag_match_encoder #(
      .N      (N_LOCATIONS),
      .BW_TAG (BW_TAG),
      .BW_IDX (BW_LOC)
   ) u_inv_enc (
      .tags_i   (tag_q),
      .key_i    (req_tag_q),
      .mask_i   (~valid_q),
      .cmp_en_i (1'b0),
      .any_o    (inv_any),
      .idx_o    (inv_idx)
   );

   // Outputs are computed for the next state so every port is a flop.
   always_comb begin
      state_d     = state_q;
      victim_d    = victim_q;
      done_d      = 1'b0;
      hit_d       = 1'b0;
      loc_d       = loc_q;
      wb_req_d    = 1'b0;
      wb_tag_d    = wb_tag_q;
      wb_loc_d    = wb_loc_q;
      fill_req_d  = 1'b0;
      fill_tag_d  = fill_tag_q;
      fill_loc_d  = fill_loc_q;
      accept      = 1'b0;
      mark_dirty  = 1'b0;
      install     = 1'b0;
      miss_victim = inv_any ? inv_idx : bus.plru_victim_i;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_i && ready_q) begin
               accept  = 1'b1;
               state_d = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (hit_any) begin
               state_d    = ST_IDLE;
               done_d     = 1'b1;
               hit_d      = 1'b1;
               loc_d      = hit_idx;
               mark_dirty = req_rw_q;
            end else begin
               victim_d = miss_victim;
               if (!inv_any && dirty_q[miss_victim]) begin
                  state_d  = ST_WB;
                  wb_req_d = 1'b1;
                  wb_tag_d = tag_q[miss_victim];
                  wb_loc_d = miss_victim;
               end else begin
                  state_d    = ST_FILL;
                  fill_req_d = 1'b1;
                  fill_tag_d = req_tag_q;
                  fill_loc_d = miss_victim;
               end
            end
         end
         ST_WB: begin
            if (bus.wb_ack_i) begin
               state_d    = ST_FILL;
               fill_req_d = 1'b1;
               fill_tag_d = req_tag_q;
               fill_loc_d = victim_q;
            end else begin
               wb_req_d = 1'b1;
            end
         end
         ST_FILL: begin
            if (bus.fill_ack_i) begin
               state_d = ST_IDLE;
               install = 1'b1;
               done_d  = 1'b1;
               loc_d   = victim_q;
            end else begin
               fill_req_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ready_d = (state_d == ST_IDLE);

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q    <= ST_IDLE;
         victim_q   <= '0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         hit_q      <= 1'b0;
         loc_q      <= '0;
         wb_req_q   <= 1'b0;
         wb_tag_q   <= '0;
         wb_loc_q   <= '0;
         fill_req_q <= 1'b0;
         fill_tag_q <= '0;
         fill_loc_q <= '0;
      end else begin
         state_q    <= state_d;
         victim_q   <= victim_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         hit_q      <= hit_d;
         loc_q      <= loc_d;
         wb_req_q   <= wb_req_d;
         wb_tag_q   <= wb_tag_d;
         wb_loc_q   <= wb_loc_d;
         fill_req_q <= fill_req_d;
         fill_tag_q <= fill_tag_d;
         fill_loc_q <= fill_loc_d;
      end
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         tag_q     <= '0;
         valid_q   <= '0;
         dirty_q   <= '0;
         req_tag_q <= '0;
         req_rw_q  <= 1'b0;
      end else begin
         if (accept) begin
            req_tag_q <= bus.tag_i;
            req_rw_q  <= bus.rw_i;
         end
         if (mark_dirty) dirty_q[hit_idx] <= 1'b1;
         if (install) begin
            valid_q[victim_q] <= 1'b1;
            tag_q[victim_q]   <= req_tag_q;
            dirty_q[victim_q] <= req_rw_q;
         end
      end
   end

   assign bus.ready_o     = ready_q;
   assign bus.done_o      = done_q;
   assign bus.hit_o       = hit_q;
   assign bus.loc_o       = loc_q;
   assign bus.plru_en_o   = done_q;
   assign bus.plru_addr_o = loc_q;
   assign bus.wb_req_o    = wb_req_q;
   assign bus.wb_tag_o    = wb_tag_q;
   assign bus.wb_loc_o    = wb_loc_q;
   assign bus.fill_req_o  = fill_req_q;
   assign bus.fill_tag_o  = fill_tag_q;
   assign bus.fill_loc_o  = fill_loc_q;

endmodule

// File: tb/tb_fa_tag_lookup.sv
// Scoreboard bench for fa_tag_lookup (4 locations, 8-bit tags): directed
// scenarios plus randomized traffic against an array-based cache model.
module tb_fa_tag_lookup;
   import cache_lookup_pkg::*;

   localparam int unsigned NL = 4;
   localparam int unsigned BT = 8;

   typedef struct {
      logic       hit;
      logic [1:0] loc;
      logic       wb;
      logic [7:0] wb_tag;
      logic [1:0] wb_loc;
      logic [7:0] fill_tag;
      int         dwb;
      int         dfill;
      int         acc;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   exp_t exp_q[$];

   logic       m_valid[NL];
   logic [7:0] m_tag[NL];
   logic       m_dirty[NL];

   logic wb_seen = 1'b0, fill_seen = 1'b0;
   logic hold_ack = 1'b0;
   logic inject_ack = 1'b0;

   fa_tag_lookup_if #(.N_LOCATIONS(NL), .BW_TAG(BT)) bus ();

   fa_tag_lookup #(.N_LOCATIONS(NL), .BW_TAG(BT)) dut (
      .clock_i  (clk),
      .resetn_i (rstn),
      .bus      (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NL; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_dirty[i] = 1'b0;
      end
   endtask

   // Resolve the request in the model, queue the expectation, drive it until accepted.
   task automatic launch(input logic [7:0] t, input logic rw, input logic [1:0] pv,
                         input int dwb, input int dfill);
      exp_t e;
      int   found, inv, v, k;
      k = 0;
      while (bus.ready_o !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("ready_before_req", bus.ready_o, 1);
      found = -1;
      inv   = -1;
      for (int i = 0; i < NL; i++) begin
         if (found < 0 && m_valid[i] && m_tag[i] == t) found = i;
         if (inv < 0 && !m_valid[i]) inv = i;
      end
      e = '{default: 0};
      e.dwb   = dwb;
      e.dfill = dfill;
      e.acc   = cyc;
      if (found >= 0) begin
         e.hit = 1'b1;
         e.loc = found[1:0];
         e.lat = 2;
         if (rw) m_dirty[found] = 1'b1;
      end else begin
         v          = (inv >= 0) ? inv : int'(pv);
         e.loc      = v[1:0];
         e.wb       = m_valid[v] && m_dirty[v];
         e.wb_tag   = m_tag[v];
         e.wb_loc   = v[1:0];
         e.fill_tag = t;
         e.lat      = 2 + (e.wb ? dwb + 1 : 0) + dfill + 1;
         m_valid[v] = 1'b1;
         m_tag[v]   = t;
         m_dirty[v] = rw;
      end
      exp_q.push_back(e);
      bus.req_i         = 1'b1;
      bus.tag_i         = t;
      bus.rw_i          = rw;
      bus.plru_victim_i = pv;
      @(negedge clk);
      bus.req_i = 1'b0;
      chk("ready_low_after_accept", bus.ready_o, 0);
   endtask

   // Wait for completion; optionally throw requests at the block while it is busy.
   task automatic finish_txn(input logic noise);
      int k;
      k = 0;
      while (bus.ready_o !== 1'b1 && k < 300) begin
         if (noise && $urandom_range(0, 2) == 0) begin
            bus.req_i = 1'b1;
            bus.tag_i = 8'($urandom);
            bus.rw_i  = 1'($urandom);
         end else begin
            bus.req_i = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      bus.req_i = 1'b0;
      chk("ready_return", bus.ready_o, 1);
   endtask

   task automatic issue(input logic [7:0] t, input logic rw, input logic [1:0] pv,
                        input int dwb, input int dfill, input logic noise);
      launch(t, rw, pv, dwb, dfill);
      finish_txn(noise);
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      exp_q.delete();
      model_clear();
      wb_seen   = 1'b0;
      fill_seen = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   // Memory-side responder: acks after the per-transaction delay, checks buses each cycle.
   initial begin
      int wcnt, fcnt;
      wcnt = 0;
      fcnt = 0;
      bus.wb_ack_i   = 1'b0;
      bus.fill_ack_i = 1'b0;
      forever begin
         @(negedge clk);
         bus.wb_ack_i   = inject_ack;
         bus.fill_ack_i = inject_ack;
         if (rstn !== 1'b1) begin
            wcnt = 0;
            fcnt = 0;
         end else begin
            if (bus.wb_req_o === 1'b1) begin
               if (exp_q.size() == 0) chk("wb_req_spurious", 1, 0);
               else begin
                  wb_seen = 1'b1;
                  chk("wb_tag", bus.wb_tag_o, exp_q[0].wb_tag);
                  chk("wb_loc", bus.wb_loc_o, exp_q[0].wb_loc);
                  if (!hold_ack) begin
                     if (wcnt >= exp_q[0].dwb) begin
                        bus.wb_ack_i = 1'b1;
                        wcnt = 0;
                     end else wcnt++;
                  end
               end
            end
            if (bus.fill_req_o === 1'b1) begin
               if (exp_q.size() == 0) chk("fill_req_spurious", 1, 0);
               else begin
                  fill_seen = 1'b1;
                  chk("fill_tag", bus.fill_tag_o, exp_q[0].fill_tag);
                  chk("fill_loc", bus.fill_loc_o, exp_q[0].loc);
                  if (!hold_ack) begin
                     if (fcnt >= exp_q[0].dfill) begin
                        bus.fill_ack_i = 1'b1;
                        fcnt = 0;
                     end else fcnt++;
                  end
               end
            end
         end
      end
   end

   // Completion monitor: pops the scoreboard on every done_o pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1) begin
            if (bus.done_o === 1'b1 || bus.plru_en_o === 1'b1)
               chk("plru_en_vs_done", bus.plru_en_o, bus.done_o);
            if (bus.done_o === 1'b1) begin
               if (exp_q.size() == 0) chk("done_spurious", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("hit", bus.hit_o, e.hit);
                  chk("loc", bus.loc_o, e.loc);
                  chk("plru_addr", bus.plru_addr_o, e.loc);
                  chk("latency", cyc - e.acc, e.lat);
                  chk("wb_seen", wb_seen, e.wb);
                  chk("fill_seen", fill_seen, !e.hit);
                  wb_seen   = 1'b0;
                  fill_seen = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rstn              = 1'b0;
      bus.req_i         = 1'b0;
      bus.tag_i         = '0;
      bus.rw_i          = 1'b0;
      bus.plru_victim_i = '0;
      model_clear();
      repeat (2) @(negedge clk);
      chk("rst_ready", bus.ready_o, 1);
      chk("rst_done_hit_plru", {bus.done_o, bus.hit_o, bus.plru_en_o}, 0);
      chk("rst_loc_addr", {bus.loc_o, bus.plru_addr_o}, 0);
      chk("rst_wb", {bus.wb_req_o, bus.wb_tag_o, bus.wb_loc_o}, 0);
      chk("rst_fill", {bus.fill_req_o, bus.fill_tag_o, bus.fill_loc_o}, 0);
      rstn = 1'b1;
      @(negedge clk);

      // Cold fill, hit, dirty and clean evictions, stretched fill with ignored requests.
      issue(8'h11, 1'b0, 2'd3, 0, 0, 1'b0);
      issue(8'h22, 1'b0, 2'd3, 0, 0, 1'b0);
      issue(8'h33, 1'b0, 2'd3, 0, 0, 1'b0);
      issue(8'h44, 1'b0, 2'd3, 0, 0, 1'b0);
      issue(8'h22, 1'b0, 2'd0, 0, 0, 1'b0);
      issue(8'h33, 1'b1, 2'd0, 0, 0, 1'b0);
      issue(8'h55, 1'b0, 2'd2, 0, 0, 1'b0);
      issue(8'h66, 1'b0, 2'd0, 0, 0, 1'b0);
      issue(8'h33, 1'b0, 2'd3, 0, 0, 1'b0);
      issue(8'h77, 1'b0, 2'd1, 0, 5, 1'b1);

      for (int n = 0; n < 150; n++) begin
         issue(8'hA0 + 8'($urandom_range(0, 7)), 1'($urandom), 2'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      end

      // Reset while a write-back is outstanding, then a stray ack in idle.
      apply_reset();
      issue(8'h11, 1'b1, 2'd0, 0, 0, 1'b0);
      issue(8'h22, 1'b1, 2'd0, 0, 0, 1'b0);
      issue(8'h33, 1'b1, 2'd0, 0, 0, 1'b0);
      issue(8'h44, 1'b1, 2'd0, 0, 0, 1'b0);
      hold_ack = 1'b1;
      launch(8'h99, 1'b0, 2'd1, 0, 0);
      k = 0;
      while (bus.wb_req_o !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("wb_req_before_reset", bus.wb_req_o, 1);
      #2 rstn = 1'b0;
      #1;
      chk("wb_req_async_drop", bus.wb_req_o, 0);
      chk("fill_req_async_drop", bus.fill_req_o, 0);
      chk("ready_async_reset", bus.ready_o, 1);
      exp_q.delete();
      model_clear();
      wb_seen   = 1'b0;
      fill_seen = 1'b0;
      hold_ack  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      #2 inject_ack = 1'b1;
      @(negedge clk);
      #2 inject_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("ready_after_stray_ack", bus.ready_o, 1);
      issue(8'h11, 1'b0, 2'd2, 0, 0, 1'b0);

      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
